// File: rtl/bp_cce_pkg.sv
// CCE shared package: coherence states, MSHR slot struct macro and the
// bit positions of the microcode field-enable vector.

`ifndef BP_CCE_PKG_MACROS
`define BP_CCE_PKG_MACROS

`define DECLARE_BP_CCE_MSHR_SLOT_S(lce_id_width_mp, lce_assoc_mp, paddr_width_mp, num_flags_mp) \
   typedef struct packed {                                  \
      logic                              valid;             \
      logic [(lce_id_width_mp)-1:0]      lce_id;            \
      logic [(paddr_width_mp)-1:0]       paddr;             \
      logic [$clog2(lce_assoc_mp)-1:0]   way_id;            \
      logic [$clog2(lce_assoc_mp)-1:0]   lru_way_id;        \
      logic [(lce_id_width_mp)-1:0]      owner_lce_id;      \
      bp_cce_pkg::bp_coh_states_e        next_coh_state;    \
      logic [(num_flags_mp)-1:0]         flags;             \
   } bp_cce_mshr_slot_s

`define BP_CCE_MSHR_SLOT_WIDTH(lce_id_width_mp, lce_assoc_mp, paddr_width_mp, num_flags_mp) \
   (1 + 2*(lce_id_width_mp) + (paddr_width_mp) \
    + 2*$clog2(lce_assoc_mp) + bp_cce_pkg::coh_bits_lp + (num_flags_mp))

`endif

package bp_cce_pkg;

   localparam int coh_bits_lp = 3;

   typedef enum logic [2:0] {
      e_COH_I = 3'd0,
      e_COH_S = 3'd1,
      e_COH_E = 3'd2,
      e_COH_F = 3'd3,
      e_COH_M = 3'd4,
      e_COH_O = 3'd5
   } bp_coh_states_e;

   // field_w_v is {lce, paddr, way, lru_way, owner_lce, next_coh_state}
   localparam int e_mshr_fld_lce      = 5;
   localparam int e_mshr_fld_paddr    = 4;
   localparam int e_mshr_fld_way      = 3;
   localparam int e_mshr_fld_lru_way  = 2;
   localparam int e_mshr_fld_owner    = 1;
   localparam int e_mshr_fld_next_coh = 0;

endpackage

// File: rtl/bp_cce_mshr_file_if.sv
// Allocate/free handshake bundle between the CCE and its MSHR file.
// master: CCE side (requests); slave: MSHR file (ready + chosen slot id).

interface bp_cce_mshr_file_if
   #(parameter int num_mshr_p     = 4,
     parameter int paddr_width_p  = 40,
     parameter int lce_id_width_p = 4);

   localparam int id_w_lp = $clog2(num_mshr_p);

   logic                      alloc_v;
   logic [paddr_width_p-1:0]  alloc_paddr;
   logic [lce_id_width_p-1:0] alloc_lce_id;
   logic                      alloc_ready;
   logic [id_w_lp-1:0]        alloc_id;
   logic                      free_v;
   logic [id_w_lp-1:0]        free_id;

   modport master (
      output alloc_v, alloc_paddr, alloc_lce_id, free_v, free_id,
      input  alloc_ready, alloc_id
   );

   modport slave (
      input  alloc_v, alloc_paddr, alloc_lce_id, free_v, free_id,
      output alloc_ready, alloc_id
   );

endinterface

// File: rtl/bp_cce_mshr_slot.sv
// One MSHR slot: registers, alloc/free/microcode write muxing and the
// block-address compare. Ports: alloc/free/w strobes, write data, slot_o.

module bp_cce_mshr_slot
   import bp_cce_pkg::*;
   #(parameter int paddr_width_p  = 40,
     parameter int lce_id_width_p = 4,
     parameter int lce_assoc_p    = 8,
     parameter int num_flags_p    = 16,
     parameter int block_offset_p = 6,
     localparam int slot_w_lp =
        `BP_CCE_MSHR_SLOT_WIDTH(lce_id_width_p, lce_assoc_p, paddr_width_p, num_flags_p))
   (input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      alloc_v_i,
    input  logic [paddr_width_p-1:0]  alloc_paddr_i,
    input  logic [lce_id_width_p-1:0] alloc_lce_id_i,
    input  logic                      free_v_i,
    input  logic                      w_v_i,
    input  logic [5:0]                field_w_v_i,
    input  logic [num_flags_p-1:0]    flag_w_mask_i,
    input  logic [num_flags_p-1:0]    flags_i,
    input  logic [paddr_width_p-1:0]  src_i,
    input  logic [paddr_width_p-1:0]  chk_paddr_i,
    output logic [slot_w_lp-1:0]      slot_o,
    output logic                      valid_o,
    output logic                      match_o);

   `DECLARE_BP_CCE_MSHR_SLOT_S(lce_id_width_p, lce_assoc_p, paddr_width_p, num_flags_p);

   localparam int way_w_lp = $clog2(lce_assoc_p);

   bp_cce_mshr_slot_s slot_q, slot_d;

   // Later assignments win: microcode, then free, then allocation.
   always_comb begin
      slot_d = slot_q;
      if (w_v_i) begin
         if (field_w_v_i[e_mshr_fld_lce])
            slot_d.lce_id = src_i[lce_id_width_p-1:0];
         if (field_w_v_i[e_mshr_fld_paddr])
            slot_d.paddr = src_i;
         if (field_w_v_i[e_mshr_fld_way])
            slot_d.way_id = src_i[way_w_lp-1:0];
         if (field_w_v_i[e_mshr_fld_lru_way])
            slot_d.lru_way_id = src_i[way_w_lp-1:0];
         if (field_w_v_i[e_mshr_fld_owner])
            slot_d.owner_lce_id = src_i[lce_id_width_p-1:0];
         if (field_w_v_i[e_mshr_fld_next_coh])
            slot_d.next_coh_state = bp_coh_states_e'(src_i[coh_bits_lp-1:0]);
         slot_d.flags = (slot_q.flags & ~flag_w_mask_i)
                      | (flags_i & flag_w_mask_i);
      end
      if (free_v_i)
         slot_d.valid = 1'b0;
      if (alloc_v_i) begin
         slot_d                = '0;
         slot_d.valid          = 1'b1;
         slot_d.paddr          = alloc_paddr_i;
         slot_d.lce_id         = alloc_lce_id_i;
         slot_d.next_coh_state = e_COH_I;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         slot_q <= '0;
      else
         slot_q <= slot_d;
   end

   assign slot_o  = slot_q;
   assign valid_o = slot_q.valid;
   assign match_o = slot_q.valid
      && (slot_q.paddr[paddr_width_p-1:block_offset_p]
          == chk_paddr_i[paddr_width_p-1:block_offset_p]);

   // Offset bits within a block never take part in the compare.
   logic unused_chk_lo;
   assign unused_chk_lo = ^chk_paddr_i[block_offset_p-1:0];

endmodule

// File: rtl/bp_cce_mshr_file.sv
// Multi-entry MSHR file plus shared GPRs for the CCE. Ports: alloc/free
// bundle, microcode select/write, GPR write, slot/GPR readout, conflict check.

module bp_cce_mshr_file
   import bp_cce_pkg::*;
   #(parameter int num_mshr_p     = 4,
     parameter int paddr_width_p  = 40,
     parameter int lce_id_width_p = 4,
     parameter int lce_assoc_p    = 8,
     parameter int num_flags_p    = 16,
     parameter int num_gpr_p      = 8,
     parameter int gpr_width_p    = 64,
     parameter int block_offset_p = 6,
     localparam int id_w_lp = $clog2(num_mshr_p),
     localparam int slot_w_lp =
        `BP_CCE_MSHR_SLOT_WIDTH(lce_id_width_p, lce_assoc_p, paddr_width_p, num_flags_p))
   (input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               stall_i,
    bp_cce_mshr_file_if.slave                  alloc_if,
    input  logic [id_w_lp-1:0]                 sel_id_i,
    input  logic [5:0]                         field_w_v_i,
    input  logic [num_flags_p-1:0]             flag_w_mask_i,
    input  logic [gpr_width_p-1:0]             src_i,
    input  logic [num_flags_p-1:0]             flags_i,
    input  logic [num_gpr_p-1:0]               gpr_w_mask_i,
    input  logic [gpr_width_p-1:0]             gpr_data_i,
    output logic [slot_w_lp-1:0]               sel_mshr_o,
    output logic [num_gpr_p*gpr_width_p-1:0]   gpr_o,
    output logic [num_mshr_p-1:0]              valid_o,
    input  logic [paddr_width_p-1:0]           chk_paddr_i,
    output logic                               conflict_o,
    output logic [id_w_lp-1:0]                 conflict_id_o);

   logic [slot_w_lp-1:0]  slot_r [num_mshr_p];
   logic [num_mshr_p-1:0] match;
   logic                  free_found;
   logic [id_w_lp-1:0]    free_id;
   logic                  alloc_go;

   // Search uses pre-free valids, so a slot freed this cycle is not reused.
   always_comb begin
      free_found = 1'b0;
      free_id    = '0;
      for (int i = num_mshr_p-1; i >= 0; i--) begin
         if (!valid_o[i]) begin
            free_found = 1'b1;
            free_id    = id_w_lp'(i);
         end
      end
   end

   assign alloc_if.alloc_ready = free_found & ~stall_i;
   assign alloc_if.alloc_id    = free_id;
   assign alloc_go = alloc_if.alloc_v & alloc_if.alloc_ready;

   for (genvar g = 0; g < num_mshr_p; g++) begin : g_slot
      bp_cce_mshr_slot #(
         .paddr_width_p  (paddr_width_p),
         .lce_id_width_p (lce_id_width_p),
         .lce_assoc_p    (lce_assoc_p),
         .num_flags_p    (num_flags_p),
         .block_offset_p (block_offset_p)
      ) slot (
         .clk_i          (clk_i),
         .reset_n_i      (reset_n_i),
         .alloc_v_i      (alloc_go && (free_id == id_w_lp'(g))),
         .alloc_paddr_i  (alloc_if.alloc_paddr),
         .alloc_lce_id_i (alloc_if.alloc_lce_id),
         .free_v_i       (alloc_if.free_v
                          && (alloc_if.free_id == id_w_lp'(g))),
         .w_v_i          (~stall_i && (sel_id_i == id_w_lp'(g))),
         .field_w_v_i    (field_w_v_i),
         .flag_w_mask_i  (flag_w_mask_i),
         .flags_i        (flags_i),
         .src_i          (src_i[paddr_width_p-1:0]),
         .chk_paddr_i    (chk_paddr_i),
         .slot_o         (slot_r[g]),
         .valid_o        (valid_o[g]),
         .match_o        (match[g])
      );
   end

   assign sel_mshr_o = slot_r[sel_id_i];

   always_comb begin
      conflict_o    = 1'b0;
      conflict_id_o = '0;
      for (int i = num_mshr_p-1; i >= 0; i--) begin
         if (match[i]) begin
            conflict_o    = 1'b1;
            conflict_id_o = id_w_lp'(i);
         end
      end
   end

   logic [num_gpr_p-1:0][gpr_width_p-1:0] gpr_q, gpr_d;

   always_comb begin
      gpr_d = gpr_q;
      if (!stall_i) begin
         for (int i = 0; i < num_gpr_p; i++) begin
            if (gpr_w_mask_i[i])
               gpr_d[i] = gpr_data_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         gpr_q <= '0;
      else
         gpr_q <= gpr_d;
   end

   assign gpr_o = gpr_q;

   // Fields only need the low paddr_width_p bits of the write data.
   if (gpr_width_p > paddr_width_p) begin : g_src_hi
      logic unused_src_hi;
      assign unused_src_hi = ^src_i[gpr_width_p-1:paddr_width_p];
   end

endmodule
